cofre_sequencial: RTL and testbench
===================================

// Module: cofre_sequencial
// PURPOSE
//  Sequential, parametrised safe controller: successor to the combinational 4-bit senha/tentativa comparator.
//  Holds a programmable password register and evaluates each attempt on a confirma rising edge.
//  Adds an error counter with timed lockout, a configurable near-miss threshold and registered outputs.
//  Its outputs drive the board LEDs and the difference display.
// PARAMETERS
//  LARGURA    4   password/attempt width in bits (>=2)
//  LIMIAR     3   near-miss threshold: |diff| <= LIMIAR asserts perto
//  MAX_TENT   3   consecutive wrong attempts that trigger lockout (>=1)
//  T_BLOQ     50_000_000  lockout duration in clk cycles (>=2)
//  SENHA_INI  0   password loaded at reset (LARGURA bits)
// PORTS
//  clk              in   1        system clock, all logic on rising edge
//  rst_n            in   1        synchronous reset, active low
//  tentativa        in   LARGURA  attempted password
//  confirma         in   1        attempt button (level); an attempt = rising edge
//  nova_senha       in   LARGURA  new password value
//  gravar           in   1        write nova_senha into password register (ABERTO only)
//  fechar           in   1        relock safe (ABERTO only)
//  aberto           out  1        safe open (led0)
//  perto            out  1        last attempt wrong but within LIMIAR (led1)
//  errada           out  1        last attempt wrong (led2)
//  bloqueado        out  1        lockout active
//  tentativas_rest  out  $clog2(MAX_TENT+1)  attempts left before lockout
//  diferenca        out  LARGURA  |senha - tentativa| of last attempt
//  sinal            out  1        1 when last tentativa > senha (negative senha-tentativa)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state FECHADO, senha_reg=SENHA_INI, erros=0, timer=0, confirma_q=0.
//   All outputs 0 except tentativas_rest=MAX_TENT. Reset overrides every state, including mid-lockout.
//  Edge detect: ev = confirma & ~confirma_q; confirma_q registered every cycle.
//   A held confirma produces one attempt only.
//  States: FECHADO, ABERTO, BLOQUEADO. tentativas_rest = MAX_TENT - erros (combinational from regs).
//  FECHADO, ev=1: compare tentativa with senha_reg. Results visible 1 cycle after the edge that samples ev.
//   diferenca=|senha_reg-tentativa| (fits LARGURA, no overflow); sinal=(tentativa>senha_reg).
//   Match: -> ABERTO; aberto=1, perto=0, errada=0, erros=0, diferenca=0, sinal=0.
//   Mismatch: errada=1; perto=(diferenca<=LIMIAR); erros=erros+1.
//    If erros+1==MAX_TENT: -> BLOQUEADO; bloqueado=1; timer=T_BLOQ-1.
//  BLOQUEADO: ev ignored (attempts discarded, no state change). timer decrements each cycle.
//   When timer==0: -> FECHADO, bloqueado=0, errada=0, perto=0, erros=0.
//   Lockout lasts exactly T_BLOQ cycles.
//   diferenca/sinal hold the last attempt's values.
//  ABERTO: ev ignored.
//   gravar=1: senha_reg<=nova_senha on that edge.
//   fechar=1: -> FECHADO, aberto=0 on that edge.
//   gravar&fechar same cycle: both take effect (new password written, safe closed).
//   gravar/fechar ignored in FECHADO and BLOQUEADO.
//  Flags perto/errada/diferenca/sinal hold until the next evaluated attempt or state exit as above.
// TESTING (LARGURA=4, LIMIAR=3, MAX_TENT=3, T_BLOQ=8, SENHA_INI=4'd5)
//  Reset, confirma edge with tentativa=5 -> aberto=1 next cycle, errada=0, tentativas_rest=3.
//  tentativa=7 edge -> errada=1, perto=1, diferenca=2, sinal=1.
//   Then tentativa=15 -> perto=0, diferenca=10, tentativas_rest=1.
//  3 wrong edges -> bloqueado=1. Edge with tentativa=5 during lock -> ignored.
//   bloqueado drops after 8 cycles, tentativas_rest=3.
//  ABERTO, gravar=1 nova_senha=9 and fechar=1 same cycle -> FECHADO.
//   tentativa=5 now wrong (sinal=0, diferenca=4); tentativa=9 opens.
//  confirma held high 20 cycles with wrong tentativa -> exactly one error counted.
//  rst_n=0 mid-lockout -> all outputs reset; senha back to 5.

Source files
------------

// File: rtl/cofre_sequencial.sv
// Sequential safe controller: programmable password, attempt evaluation,
// error counting with timed lockout and registered result flags.
module cofre_sequencial #(
  parameter int LARGURA  = 4,
  parameter int LIMIAR   = 3,
  parameter int MAX_TENT = 3,
  parameter int T_BLOQ   = 50_000_000,
  parameter logic [LARGURA-1:0] SENHA_INI = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LARGURA-1:0]   tentativa,
  input  logic                 confirma,
  input  logic [LARGURA-1:0]   nova_senha,
  input  logic                 gravar,
  input  logic                 fechar,
  output logic                 aberto,
  output logic                 perto,
  output logic                 errada,
  output logic                 bloqueado,
  output logic [$clog2(MAX_TENT+1)-1:0] tentativas_rest,
  output logic [LARGURA-1:0]   diferenca,
  output logic                 sinal
);

  localparam int CW = $clog2(MAX_TENT + 1);
  localparam int TW = (T_BLOQ > 1) ? $clog2(T_BLOQ) : 1;

  localparam logic [CW-1:0] MAXT = CW'(MAX_TENT);
  localparam logic [TW-1:0] TINI = TW'(T_BLOQ - 1);

  typedef enum logic [1:0] {
    FECHADO,
    ABERTO,
    BLOQUEADO
  } estado_t;

  estado_t            estado, estado_d;
  logic [LARGURA-1:0] senha_reg, senha_d;
  logic [CW-1:0]      erros, erros_d;
  logic [TW-1:0]      timer, timer_d;
  logic               confirma_q;
  logic               perto_q, perto_d;
  logic               errada_q, errada_d;
  logic [LARGURA-1:0] dif_q, dif_d;
  logic               sinal_q, sinal_d;

  logic               ev;
  logic               maior;
  logic [LARGURA-1:0] dif_c;

  assign ev    = confirma & ~confirma_q;
  assign maior = tentativa > senha_reg;
  assign dif_c = maior ? tentativa - senha_reg
                       : senha_reg - tentativa;

  always_comb begin
    estado_d = estado;
    senha_d  = senha_reg;
    erros_d  = erros;
    timer_d  = timer;
    perto_d  = perto_q;
    errada_d = errada_q;
    dif_d    = dif_q;
    sinal_d  = sinal_q;
    unique case (estado)
      FECHADO: begin
        if (ev) begin
          if (tentativa == senha_reg) begin
            estado_d = ABERTO;
            perto_d  = 1'b0;
            errada_d = 1'b0;
            erros_d  = '0;
            dif_d    = '0;
            sinal_d  = 1'b0;
          end else begin
            errada_d = 1'b1;
            perto_d  = int'(dif_c) <= LIMIAR;
            dif_d    = dif_c;
            sinal_d  = maior;
            erros_d  = erros + CW'(1);
            if (erros == MAXT - CW'(1)) begin
              estado_d = BLOQUEADO;
              timer_d  = TINI;
            end
          end
        end
      end
      BLOQUEADO: begin
        // timer was preloaded with T_BLOQ-1 so the lock spans T_BLOQ cycles
        if (timer == '0) begin
          estado_d = FECHADO;
          errada_d = 1'b0;
          perto_d  = 1'b0;
          erros_d  = '0;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      ABERTO: begin
        if (gravar) senha_d = nova_senha;
        if (fechar) estado_d = FECHADO;
      end
      default: estado_d = FECHADO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado     <= FECHADO;
      senha_reg  <= SENHA_INI;
      erros      <= '0;
      timer      <= '0;
      confirma_q <= 1'b0;
      perto_q    <= 1'b0;
      errada_q   <= 1'b0;
      dif_q      <= '0;
      sinal_q    <= 1'b0;
    end else begin
      estado     <= estado_d;
      senha_reg  <= senha_d;
      erros      <= erros_d;
      timer      <= timer_d;
      confirma_q <= confirma;
      perto_q    <= perto_d;
      errada_q   <= errada_d;
      dif_q      <= dif_d;
      sinal_q    <= sinal_d;
    end
  end

  assign aberto          = estado == ABERTO;
  assign bloqueado       = estado == BLOQUEADO;
  assign tentativas_rest = MAXT - erros;
  assign perto           = perto_q;
  assign errada          = errada_q;
  assign diferenca       = dif_q;
  assign sinal           = sinal_q;

endmodule

// File: tb/tb_cofre_sequencial.sv
// Bench for cofre_sequencial: directed scenarios then random traffic,
// all outputs compared each cycle against a behavioural model.
module tb_cofre_sequencial;

  localparam int LARGURA  = 4;
  localparam int LIMIAR   = 3;
  localparam int MAX_TENT = 3;
  localparam int T_BLOQ   = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] tentativa;
  logic       confirma;
  logic [3:0] nova_senha;
  logic       gravar;
  logic       fechar;
  logic       aberto;
  logic       perto;
  logic       errada;
  logic       bloqueado;
  logic [1:0] tentativas_rest;
  logic [3:0] diferenca;
  logic       sinal;

  int total;
  int bad;

  // behavioural model state
  int m_senha;
  int m_err;
  bit m_open;
  bit m_locked;
  int m_lock_age;
  bit m_cq;
  bit m_perto;
  bit m_errada;
  int m_dif;
  bit m_sinal;

  cofre_sequencial #(
    .LARGURA  (LARGURA),
    .LIMIAR   (LIMIAR),
    .MAX_TENT (MAX_TENT),
    .T_BLOQ   (T_BLOQ),
    .SENHA_INI(4'd5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tentativa      (tentativa),
    .confirma       (confirma),
    .nova_senha     (nova_senha),
    .gravar         (gravar),
    .fechar         (fechar),
    .aberto         (aberto),
    .perto          (perto),
    .errada         (errada),
    .bloqueado      (bloqueado),
    .tentativas_rest(tentativas_rest),
    .diferenca      (diferenca),
    .sinal          (sinal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_senha    = 5;
    m_err      = 0;
    m_open     = 0;
    m_locked   = 0;
    m_lock_age = 0;
    m_cq       = 0;
    m_perto    = 0;
    m_errada   = 0;
    m_dif      = 0;
    m_sinal    = 0;
  endtask

  task automatic model_edge(input bit r, input int t, input bit c,
                            input int n, input bit g, input bit f);
    bit ev;
    int d;
    int a;
    if (!r) begin
      model_reset();
      return;
    end
    ev   = c && !m_cq;
    m_cq = c;
    if (m_locked) begin
      m_lock_age++;
      if (m_lock_age == T_BLOQ) begin
        m_locked = 0;
        m_err    = 0;
        m_errada = 0;
        m_perto  = 0;
      end
    end else if (m_open) begin
      if (g) m_senha = n;
      if (f) m_open = 0;
    end else if (ev) begin
      d = t - m_senha;
      a = (d < 0) ? -d : d;
      if (d == 0) begin
        m_open   = 1;
        m_err    = 0;
        m_perto  = 0;
        m_errada = 0;
        m_dif    = 0;
        m_sinal  = 0;
      end else begin
        m_errada = 1;
        m_perto  = a <= LIMIAR;
        m_dif    = a;
        m_sinal  = d > 0;
        m_err++;
        if (m_err == MAX_TENT) begin
          m_locked   = 1;
          m_lock_age = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    check("m_aberto", 32'(aberto), 32'(m_open));
    check("m_bloq", 32'(bloqueado), 32'(m_locked));
    check("m_errada", 32'(errada), 32'(m_errada));
    check("m_perto", 32'(perto), 32'(m_perto));
    check("m_dif", 32'(diferenca), 32'(m_dif));
    check("m_sinal", 32'(sinal), 32'(m_sinal));
    check("m_rest", 32'(tentativas_rest), 32'(MAX_TENT - m_err));
  endtask

  task automatic tick(input bit r, input int t, input bit c,
                      input int n = 0, input bit g = 0,
                      input bit f = 0);
    rst_n      = r;
    tentativa  = 4'(t);
    confirma   = c;
    nova_senha = 4'(n);
    gravar     = g;
    fechar     = f;
    @(posedge clk);
    model_edge(r, t & 15, c, n & 15, g, f);
    #1;
    check_model();
  endtask

  initial begin
    int rt;
    total = 0;
    bad   = 0;
    model_reset();
    rst_n      = 1'b0;
    tentativa  = '0;
    confirma   = 1'b0;
    nova_senha = '0;
    gravar     = 1'b0;
    fechar     = 1'b0;

    tick(0, 0, 0);
    tick(0, 0, 0);
    check("rst_aberto", 32'(aberto), 0);
    check("rst_rest", 32'(tentativas_rest), 3);
    check("rst_dif", 32'(diferenca), 0);

    tick(1, 5, 1);
    check("open5", 32'(aberto), 1);
    check("open5_err", 32'(errada), 0);
    check("open5_rest", 32'(tentativas_rest), 3);
    tick(1, 5, 0);
    tick(1, 5, 0, 0, 0, 1);
    check("closed", 32'(aberto), 0);

    tick(1, 7, 1);
    check("t7_err", 32'(errada), 1);
    check("t7_perto", 32'(perto), 1);
    check("t7_dif", 32'(diferenca), 2);
    check("t7_sinal", 32'(sinal), 1);
    tick(1, 7, 0);
    tick(1, 15, 1);
    check("t15_perto", 32'(perto), 0);
    check("t15_dif", 32'(diferenca), 10);
    check("t15_rest", 32'(tentativas_rest), 1);
    tick(1, 15, 0);
    tick(1, 0, 1);
    check("lock_on", 32'(bloqueado), 1);
    check("lock_rest", 32'(tentativas_rest), 0);
    tick(1, 0, 0);
    tick(1, 5, 1);
    check("lock_ign", 32'(aberto), 0);
    tick(1, 5, 0);
    repeat (4) tick(1, 5, 0);
    check("lock_7", 32'(bloqueado), 1);
    tick(1, 5, 0);
    check("lock_off", 32'(bloqueado), 0);
    check("unlock_rest", 32'(tentativas_rest), 3);
    check("unlock_err", 32'(errada), 0);
    check("unlock_dif", 32'(diferenca), 5);

    tick(1, 5, 1);
    check("reopen", 32'(aberto), 1);
    tick(1, 5, 0, 9, 1, 1);
    check("grav_fech", 32'(aberto), 0);
    tick(1, 5, 1);
    check("old_pw_err", 32'(errada), 1);
    check("old_pw_sinal", 32'(sinal), 0);
    check("old_pw_dif", 32'(diferenca), 4);
    tick(1, 9, 0);
    tick(1, 9, 1);
    check("new_pw", 32'(aberto), 1);
    tick(1, 9, 0, 0, 0, 1);

    repeat (20) tick(1, 3, 1);
    check("held_rest", 32'(tentativas_rest), 2);
    tick(1, 0, 0);
    tick(1, 0, 1);
    tick(1, 0, 0);
    tick(1, 0, 1);
    tick(1, 0, 0);
    check("lock2", 32'(bloqueado), 1);
    tick(0, 0, 0);
    check("rst_bloq", 32'(bloqueado), 0);
    check("rst_err", 32'(errada), 0);
    check("rst_rest2", 32'(tentativas_rest), 3);
    tick(1, 5, 1);
    check("rst_pw5", 32'(aberto), 1);
    tick(1, 5, 0, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      rt = ($urandom % 3 == 0) ? m_senha : int'($urandom % 16);
      tick(($urandom % 120) != 0, rt, ($urandom % 2) == 1,
           int'($urandom % 16), ($urandom % 6) == 0,
           ($urandom % 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
